// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: funct3 encodings, FSM states
// and the signed/remainder decode helpers.
package div_pkg;

  typedef enum logic [2:0] {
    OP_DIV  = 3'b100,
    OP_DIVU = 3'b101,
    OP_REM  = 3'b110,
    OP_REMU = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_iter_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [XLEN-1:0]       dividend_i;
  logic [XLEN-1:0]       divisor_i;
  logic [REG_ADDR_W-1:0] reg_waddr_i;
  logic                  flush_i;
  logic [XLEN-1:0]       result_o;
  logic                  ready_o;
  logic                  busy_o;
  logic [REG_ADDR_W-1:0] reg_waddr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[XLEN];
  // After a successful subtract the difference is below the divisor, so XLEN bits suffice.
  assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/div_iter.sv
// Iterative DIV/DIVU/REM/REMU unit, BITS_PER_CYCLE quotient bits per clock.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish at acceptance.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int REG_ADDR_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);
  localparam int K     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K);

  div_state_e state_reg, state_next;
  logic accept, last_iter, early_out, busy, ready;

  logic [CNT_W-1:0]      cnt_reg;
  logic [XLEN-1:0]       rem_reg, quo_reg, divisor_reg, result_reg;
  logic [REG_ADDR_W-1:0] waddr_pend_reg, waddr_reg;
  logic                  op_rem_reg, q_neg_reg, r_neg_reg;

  logic            in_signed, in_rem, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_mag, b_mag, early_result;

  assign in_signed = op_is_signed(bus.op_i);
  assign in_rem    = op_is_rem(bus.op_i);
  assign a_neg     = in_signed & bus.dividend_i[XLEN-1];
  assign b_neg     = in_signed & bus.divisor_i[XLEN-1];
  assign b_zero    = (bus.divisor_i == '0);
  assign a_mag     = a_neg ? -bus.dividend_i : bus.dividend_i;
  assign b_mag     = b_neg ? -bus.divisor_i : bus.divisor_i;

`ifdef DIV_EARLY_OUT_EN
  logic in_ovf;
  assign in_ovf    = in_signed & (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.divisor_i);
  assign early_out = b_zero | in_ovf;

  // Overflow quotient equals the dividend itself (-2^(XLEN-1)).
  always_comb begin
    early_result = '0;
    if (b_zero) early_result = in_rem ? bus.dividend_i : '1;
    else        early_result = in_rem ? '0 : bus.dividend_i;
  end
`else
  assign early_out    = 1'b0;
  assign early_result = '0;
`endif

  logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_chain;
  logic [BITS_PER_CYCLE-1:0]         q_bits;
  logic [XLEN-1:0] quo_next, rem_final, q_signed, r_signed, final_result;

  assign rem_chain[0] = rem_reg;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      div_step #(.XLEN(XLEN)) u_step (
        .rem          (rem_chain[gi]),
        .dividend_bit (quo_reg[XLEN-1-gi]),
        .divisor      (divisor_reg),
        .rem_next     (rem_chain[gi+1]),
        .q_bit        (q_bits[BITS_PER_CYCLE-1-gi])
      );
    end
  endgenerate

  // quo_reg shifts the dividend out at the top while quotient bits enter at the bottom.
  assign quo_next     = {quo_reg[XLEN-BITS_PER_CYCLE-1:0], q_bits};
  assign rem_final    = rem_chain[BITS_PER_CYCLE];
  assign q_signed     = q_neg_reg ? -quo_next : quo_next;
  assign r_signed     = r_neg_reg ? -rem_final : rem_final;
  assign final_result = op_rem_reg ? r_signed : q_signed;

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg == CALC);
    ready      = (state_reg == DONE);
    accept     = bus.start_i & bus.op_i[2] & ~bus.flush_i &
                 ((state_reg == IDLE) | (state_reg == DONE));
    last_iter  = (state_reg == CALC) && (cnt_reg == CNT_W'(K - 1));
    if (bus.flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = early_out ? DONE : CALC;
        CALC:    if (last_iter) state_next = DONE;
        DONE:    state_next = accept ? (early_out ? DONE : CALC) : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      divisor_reg    <= '0;
      result_reg     <= '0;
      waddr_pend_reg <= '0;
      waddr_reg      <= '0;
      op_rem_reg     <= 1'b0;
      q_neg_reg      <= 1'b0;
      r_neg_reg      <= 1'b0;
    end else if (accept) begin
      quo_reg        <= a_mag;
      rem_reg        <= '0;
      divisor_reg    <= b_mag;
      cnt_reg        <= '0;
      op_rem_reg     <= in_rem;
      // A zero divisor yields an all-ones quotient magnitude that must stay positive.
      q_neg_reg      <= (a_neg ^ b_neg) & ~b_zero;
      r_neg_reg      <= a_neg;
      waddr_pend_reg <= bus.reg_waddr_i;
      if (early_out) begin
        result_reg <= early_result;
        waddr_reg  <= bus.reg_waddr_i;
      end
    end else if ((state_reg == CALC) && !bus.flush_i) begin
      quo_reg <= quo_next;
      rem_reg <= rem_final;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (last_iter) begin
        result_reg <= final_result;
        waddr_reg  <= waddr_pend_reg;
      end
    end
  end

  assign bus.busy_o      = busy;
  assign bus.ready_o     = ready;
  assign bus.result_o    = result_reg;
  assign bus.reg_waddr_o = waddr_reg;
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results, latency and flush scenarios.
module tb_div_iter;
  import div_pkg::*;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int RAW  = 5;
  localparam int K    = XLEN / BPC;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) bus ();

  div_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .REG_ADDR_W(RAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V M semantics straight from the arithmetic definitions.
  function automatic logic [XLEN-1:0] model_result(logic [2:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  if (b == '0) return '1;
               else if (a == MIN && b == '1) return MIN;
               else return sa / sb;
      OP_DIVU: if (b == '0) return '1;
               else return a / b;
      OP_REM:  if (b == '0) return a;
               else if (a == MIN && b == '1) return '0;
               else return sa % sb;
      OP_REMU: if (b == '0) return a;
               else return a % b;
      default: return '0;
    endcase
  endfunction

  function automatic bit early_case(logic [2:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    bit special;
    special = (b == '0) || (((op == OP_DIV) || (op == OP_REM)) && (a == MIN) && (b == '1));
`ifdef DIV_EARLY_OUT_EN
    return special;
`else
    return special & 1'b0;
`endif
  endfunction

  // Reference timing: a countdown of remaining busy cycles.
  int                  m_rem = 0;
  logic                m_ready, m_busy;
  logic [XLEN-1:0]     m_result, m_pend;
  logic [RAW-1:0]      m_waddr, m_pend_wa;
  bit                  model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_ready = 1'b0; m_busy = 1'b0;
      m_result = '0; m_waddr = '0;
      model_valid = 1'b1;
    end else begin
      m_ready = 1'b0;
      if (bus.flush_i) begin
        m_rem = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_result = m_pend; m_waddr = m_pend_wa; m_ready = 1'b1;
        end
      end else if (bus.start_i && bus.op_i[2]) begin
        m_pend    = model_result(bus.op_i, bus.dividend_i, bus.divisor_i);
        m_pend_wa = bus.reg_waddr_i;
        if (early_case(bus.op_i, bus.dividend_i, bus.divisor_i)) begin
          m_result = m_pend; m_waddr = m_pend_wa; m_ready = 1'b1;
        end else begin
          m_rem = K;
        end
      end
      m_busy = (m_rem > 0);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc busy_o", XLEN'(bus.busy_o), XLEN'(m_busy));
      check("cyc ready_o", XLEN'(bus.ready_o), XLEN'(m_ready));
      check("cyc result_o", bus.result_o, m_result);
      check("cyc reg_waddr_o", XLEN'(bus.reg_waddr_o), XLEN'(m_waddr));
    end
  end

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RAW-1:0]  wa;
    logic [XLEN-1:0] exp;
    bit              chain;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [RAW-1:0] wa, input logic [XLEN-1:0] exp, input bit chain);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.wa = wa; v.exp = exp; v.chain = chain;
    vq.push_back(v);
  endtask

  // Issue at a negedge; returns at the negedge of the ready_o cycle.
  task automatic do_op(input vec_t v, input int idx);
    int lat, nbusy;
    bit early;
    early = early_case(v.op, v.a, v.b);
    bus.start_i = 1'b1; bus.op_i = v.op; bus.dividend_i = v.a;
    bus.divisor_i = v.b; bus.reg_waddr_i = v.wa;
    @(negedge clk);
    bus.start_i = 1'b0; bus.dividend_i = $urandom; bus.divisor_i = $urandom;
    bus.reg_waddr_i = ~v.wa;
    lat = 0; nbusy = 0;
    while (bus.ready_o !== 1'b1 && lat <= 4 * K) begin
      if (bus.busy_o === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (bus.ready_o !== 1'b1) begin
      total++; bad++;
      $display("FAIL vec%0d ready_o timeout: got none after %0d cycles, expected after %0d", idx, lat, K);
    end else begin
      check($sformatf("vec%0d result_o", idx), bus.result_o, v.exp);
      check($sformatf("vec%0d reg_waddr_o", idx), XLEN'(bus.reg_waddr_o), XLEN'(v.wa));
      check($sformatf("vec%0d latency", idx), XLEN'(lat), early ? '0 : XLEN'(K));
      check($sformatf("vec%0d busy cycles", idx), XLEN'(nbusy), early ? '0 : XLEN'(K));
    end
    $display("op=%b a=%h b=%h rd=%0d -> result=%h rd_o=%0d latency=%0d busy=%0d",
             v.op, v.a, v.b, v.wa, bus.result_o, bus.reg_waddr_o, lat, nbusy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.op_i = '0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.reg_waddr_i = '0; bus.flush_i = 1'b0;

    add(OP_DIVU, 32'd14,        32'd2,        5'd1,  32'd7,        1'b0);
    add(OP_DIV,  32'hFFFFFFF9,  32'd2,        5'd2,  32'hFFFFFFFD, 1'b1);
    add(OP_REM,  32'hFFFFFFF9,  32'd2,        5'd3,  32'hFFFFFFFF, 1'b0);
    add(OP_REMU, 32'hFFFFFFF9,  32'd2,        5'd4,  32'd1,        1'b1);
    add(OP_DIV,  32'd5,         32'd0,        5'd5,  32'hFFFFFFFF, 1'b0);
    add(OP_REM,  32'd5,         32'd0,        5'd6,  32'd5,        1'b1);
    add(OP_DIV,  32'hFFFFFFFB,  32'd0,        5'd7,  32'hFFFFFFFF, 1'b1);
    add(OP_DIV,  32'h80000000,  32'hFFFFFFFF, 5'd8,  32'h80000000, 1'b0);
    add(OP_REM,  32'h80000000,  32'hFFFFFFFF, 5'd9,  32'd0,        1'b1);
    add(OP_DIV,  32'd7,         32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 1'b0);
    add(OP_DIVU, 32'd100,       32'd7,        5'd11, 32'd14,       1'b1);
    add(OP_DIVU, 32'd9,         32'd3,        5'd12, 32'd3,        1'b1);
    add(OP_REM,  32'd7,         32'hFFFFFFFE, 5'd13, 32'd1,        1'b1);
    add(OP_REMU, 32'd5,         32'd0,        5'd14, 32'd5,        1'b0);
    add(OP_DIVU, 32'hFFFFFFFF,  32'd1,        5'd15, 32'hFFFFFFFF, 1'b1);
    add(OP_DIV,  32'h80000000,  32'd1,        5'd16, 32'h80000000, 1'b0);

    repeat (3) @(negedge clk);
    check("reset busy_o", XLEN'(bus.busy_o), '0);
    check("reset ready_o", XLEN'(bus.ready_o), '0);
    check("reset result_o", bus.result_o, '0);
    check("reset reg_waddr_o", XLEN'(bus.reg_waddr_o), '0);
    rst = 1'b0;
    @(negedge clk);

    // Non-M funct3 is ignored.
    bus.start_i = 1'b1; bus.op_i = 3'b001; bus.dividend_i = 32'd10; bus.divisor_i = 32'd2;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("ignored op busy_o", XLEN'(bus.busy_o), '0);
    $display("start with op=001 -> busy=%b", bus.busy_o);

    // Start in the same cycle as flush is dropped.
    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("start+flush busy_o", XLEN'(bus.busy_o), '0);
    $display("start with flush -> busy=%b", bus.busy_o);

    for (int i = 0; i < 10; i++) begin
      if (!vq[i].chain) @(negedge clk);
      do_op(vq[i], i);
    end

    // Flush ten cycles into CALC; previous result (vec9) must survive.
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.dividend_i = 32'h1234;
    bus.divisor_i = 32'd5; bus.reg_waddr_i = 5'd20;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush busy_o", XLEN'(bus.busy_o), '0);
    check("flush ready_o", XLEN'(bus.ready_o), '0);
    check("flush result_o kept", bus.result_o, 32'hFFFFFFFD);
    check("flush reg_waddr_o kept", XLEN'(bus.reg_waddr_o), XLEN'(5'd10));
    $display("flush in CALC -> busy=%b ready=%b result=%h", bus.busy_o, bus.ready_o, bus.result_o);

    for (int i = 10; i < vq.size(); i++) begin
      if (!vq[i].chain) @(negedge clk);
      do_op(vq[i], i);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
